op_queue: RTL and testbench



---
 rtl/op_queue.sv | 112 +++++++++++
 tb/tb_op_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/op_queue.sv
// Circular 4-in / 2-out operation queue between the compacting feeder and issue.
// Define OP_QUEUE_ERROR_CHECK_EN to add the sticky protoError output and protocol clamping.
module op_queue #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 57
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           inOperationA,
    input  logic [WIDTH-1:0]           inOperationB,
    input  logic [WIDTH-1:0]           inOperationC,
    input  logic [WIDTH-1:0]           inOperationD,
    input  logic                       inValidA,
    input  logic                       inValidB,
    input  logic                       inValidC,
    input  logic                       inValidD,
    output logic                       enqReady,
    output logic [WIDTH-1:0]           outOperationA,
    output logic [WIDTH-1:0]           outOperationB,
    output logic                       outValidA,
    output logic                       outValidB,
    input  logic [1:0]                 deqCount,
    input  logic                       flush,
`ifdef OP_QUEUE_ERROR_CHECK_EN
    output logic                       protoError,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [3:0]            vld;
    logic [3:0][WIDTH-1:0] ops;
    logic [2:0]            n_enq;
    logic [1:0]            n_deq;

    assign vld = {inValidD, inValidC, inValidB, inValidA};
    assign ops = {inOperationD, inOperationC, inOperationB, inOperationA};

    // Credit comes only from registered occupancy, so deqCount never reaches enqReady.
    assign enqReady      = (count <= CW'(DEPTH - 4));
    assign outValidA     = (count != '0);
    assign outValidB     = (count >= CW'(2));
    assign outOperationA = mem[head];
    assign outOperationB = mem[head + PW'(1)];

`ifdef OP_QUEUE_ERROR_CHECK_EN
    logic [1:0] avail;
    logic       enq_err;
    logic       deq_err;

    assign avail   = {1'b0, outValidA} + {1'b0, outValidB};
    assign enq_err = ((|vld) && !enqReady) ||
                     !(vld inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
    assign deq_err = (deqCount == 2'd3) || (deqCount > avail);
`endif

    always_comb begin
        n_enq = '0;
        n_deq = deqCount;
        if (enqReady)
            n_enq = {2'b0, vld[0]} + {2'b0, vld[1]} + {2'b0, vld[2]} + {2'b0, vld[3]};
        if (count == '0)
            n_deq = '0;
`ifdef OP_QUEUE_ERROR_CHECK_EN
        if (enq_err)
            n_enq = '0;
        if (deq_err)
            n_deq = avail;
`endif
    end

    // Storage is intentionally unreset; slots are written oldest-first from tail.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < n_enq)
                    mem[tail + PW'(k)] <= ops[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(n_enq);
            count <= count + CW'(n_enq) - CW'(n_deq);
        end
    end

`ifdef OP_QUEUE_ERROR_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            protoError <= 1'b0;
        else if (enq_err || deq_err)
            protoError <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_op_queue.sv
// Directed bench for op_queue: a queue model tracks expected contents in order
// and every step compares occupancy, handshake and the two head entries.
module tb_op_queue;

    localparam int DEPTH = 16;
    localparam int WIDTH = 57;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] inOperationA, inOperationB, inOperationC, inOperationD;
    logic             inValidA, inValidB, inValidC, inValidD;
    logic             enqReady;
    logic [WIDTH-1:0] outOperationA, outOperationB;
    logic             outValidA, outValidB;
    logic [1:0]       deqCount;
    logic             flush;
    logic [4:0]       count;
`ifdef OP_QUEUE_ERROR_CHECK_EN
    logic             protoError;
`endif

    op_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .inOperationA(inOperationA), .inOperationB(inOperationB),
        .inOperationC(inOperationC), .inOperationD(inOperationD),
        .inValidA(inValidA), .inValidB(inValidB),
        .inValidC(inValidC), .inValidD(inValidD),
        .enqReady(enqReady),
        .outOperationA(outOperationA), .outOperationB(outOperationB),
        .outValidA(outValidA), .outValidB(outValidB),
        .deqCount(deqCount), .flush(flush),
`ifdef OP_QUEUE_ERROR_CHECK_EN
        .protoError(protoError),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] sb [$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = sb.size();
        chk({tag, "_count"}, 64'(count), 64'(sz));
        chk({tag, "_enqReady"}, 64'(enqReady), 64'((DEPTH - sz) >= 4));
        chk({tag, "_validA"}, 64'(outValidA), 64'(sz >= 1));
        chk({tag, "_validB"}, 64'(outValidB), 64'(sz >= 2));
        if (sz >= 1) chk({tag, "_opA"}, 64'(outOperationA), 64'(sb[0]));
        if (sz >= 2) chk({tag, "_opB"}, 64'(outOperationB), 64'(sb[1]));
    endtask

    task automatic idle_inputs();
        inValidA = 0; inValidB = 0; inValidC = 0; inValidD = 0;
        inOperationA = '0; inOperationB = '0; inOperationC = '0; inOperationD = '0;
        deqCount = 0; flush = 0;
    endtask

    // One clock: drive, let the edge pass, then advance the model with the same inputs.
    task automatic step(input logic [3:0] v, input logic [1:0] dq, input logic fl,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] o [4];
        bit ready;
        bit legal;
        int n;
        inValidA = v[0]; inValidB = v[1]; inValidC = v[2]; inValidD = v[3];
        inOperationA = a; inOperationB = b; inOperationC = c; inOperationD = d;
        deqCount = dq; flush = fl;
        o[0] = a; o[1] = b; o[2] = c; o[3] = d;
        ready = (DEPTH - sb.size()) >= 4;
        legal = v inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        n = int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            for (int i = 0; i < int'(dq); i++)
                if (sb.size() > 0) void'(sb.pop_front());
            if (ready && legal)
                for (int i = 0; i < n; i++) sb.push_back(o[i]);
        end
        idle_inputs();
    endtask

    initial begin
        logic [WIDTH-1:0] r0, r1, r2, r3;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("idle");

        // basic enqueue of a full group
        step(4'b1111, 2'd0, 1'b0, 57'h1, 57'h2, 57'h3, 57'h4);
        check_state("enq4");
        chk("enq4_opA_const", 64'(outOperationA), 64'h1);
        chk("enq4_opB_const", 64'(outOperationB), 64'h2);
        step(4'b0000, 2'd1, 1'b0, '0, '0, '0, '0);
        check_state("deq1");
        step(4'b0000, 2'd2, 1'b0, '0, '0, '0, '0);
        check_state("deq2");
        step(4'b0000, 2'd1, 1'b0, '0, '0, '0, '0);
        check_state("drain");
        step(4'b0000, 2'd0, 1'b0, '0, '0, '0, '0);
        check_state("empty_idle");

        // fill to 13 with wide random payloads
        for (int g = 0; g < 3; g++) begin
            r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
            step(4'b1111, 2'd0, 1'b0, r0, r1, r2, r3);
            check_state("fill");
        end
        step(4'b0001, 2'd0, 1'b0, 57'h1_2345_6789_ABCD, '0, '0, '0);
        check_state("fill13");
        chk("fill13_ready_low", 64'(enqReady), 64'h0);
        step(4'b1111, 2'd0, 1'b0, 57'h77, 57'h78, 57'h79, 57'h7A);
        check_state("hold_full");
        chk("hold_count13", 64'(count), 64'd13);
        step(4'b1111, 2'd2, 1'b0, 57'h77, 57'h78, 57'h79, 57'h7A);
        check_state("full_deq2");
        chk("full_deq2_count11", 64'(count), 64'd11);
        chk("full_deq2_ready", 64'(enqReady), 64'h1);

        // walk both pointers to 14 with the queue empty, then straddle the wrap
        step(4'b0000, 2'd0, 1'b1, '0, '0, '0, '0);
        check_state("flush_setup");
        step(4'b0011, 2'd0, 1'b0, 57'h100, 57'h101, '0, '0);
        for (int i = 0; i < 6; i++) begin
            step(4'b0011, 2'd2, 1'b0, 57'(200 + 2 * i), 57'(201 + 2 * i), '0, '0);
            check_state("walk");
        end
        step(4'b0000, 2'd2, 1'b0, '0, '0, '0, '0);
        check_state("at14_empty");
        step(4'b1111, 2'd0, 1'b0, 57'hA, 57'hB, 57'hC, 57'hD);
        check_state("wrap_enq");
        chk("wrap_opA_A", 64'(outOperationA), 64'hA);
        step(4'b0000, 2'd2, 1'b0, '0, '0, '0, '0);
        check_state("wrap_deq");
        chk("wrap_opA_C", 64'(outOperationA), 64'hC);
        chk("wrap_opB_D", 64'(outOperationB), 64'hD);

        // simultaneous enqueue and dequeue at count=3
        step(4'b0001, 2'd0, 1'b0, 57'hE, '0, '0, '0);
        check_state("sim_pre");
        step(4'b0011, 2'd2, 1'b0, 57'hF, 57'h10, '0, '0);
        check_state("sim");
        chk("sim_count3", 64'(count), 64'd3);
        chk("sim_opA_third", 64'(outOperationA), 64'hE);

        // flush beats enqueue and dequeue
        step(4'b1111, 2'd1, 1'b1, 57'h21, 57'h22, 57'h23, 57'h24);
        check_state("flush");
        chk("flush_validA", 64'(outValidA), 64'h0);
        step(4'b0111, 2'd0, 1'b0, 57'h31, 57'h32, 57'h33, '0);
        check_state("post_flush_enq");

        // asynchronous reset mid-operation
        inValidA = 1; inOperationA = 57'h55;
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("async_rst_count", 64'(count), 64'h0);
        chk("async_rst_validA", 64'(outValidA), 64'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        check_state("after_rst");

`ifdef OP_QUEUE_ERROR_CHECK_EN
        chk("perr_clear", 64'(protoError), 64'h0);
        step(4'b0010, 2'd0, 1'b0, '0, 57'h99, '0, '0);
        check_state("hole_dropped");
        chk("perr_set", 64'(protoError), 64'h1);
        step(4'b0000, 2'd0, 1'b0, '0, '0, '0, '0);
        chk("perr_sticky", 64'(protoError), 64'h1);
        rst = 1'b1;
        #1;
        chk("perr_rst", 64'(protoError), 64'h0);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
